// File: rtl/async_reset_sync_load_register.sv
// Holding register with asynchronous active-low reset and synchronous load enable.
// Status outputs report loaded data (valid), value-changing loads (changed) and the prior value (q_prev).
module async_reset_sync_load_register #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             changed,
  output logic [WIDTH-1:0] q_prev
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_prev_reg;
  logic [WIDTH-1:0] q_prev_next;
  logic             valid_reg;
  logic             valid_next;
  logic             changed_reg;
  logic             changed_next;
  logic [WIDTH-1:0] diff_bits;

  // Per-bit difference between incoming data and the currently held value.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign diff_bits[gi] = d[gi] ^ q_reg[gi];
    end
  endgenerate

  always_comb begin
    q_next       = q_reg;
    q_prev_next  = q_prev_reg;
    valid_next   = valid_reg;
    changed_next = 1'b0;
    if (load) begin
      q_next       = d;
      q_prev_next  = q_reg;
      valid_next   = 1'b1;
      changed_next = |diff_bits;
    end
  end

  // Reset is checked first so an edge coincident with reset never loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg       <= RESET_VALUE;
      q_prev_reg  <= RESET_VALUE;
      valid_reg   <= 1'b0;
      changed_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      q_prev_reg  <= q_prev_next;
      valid_reg   <= valid_next;
      changed_reg <= changed_next;
    end
  end

  assign q       = q_reg;
  assign q_prev  = q_prev_reg;
  assign valid   = valid_reg;
  assign changed = changed_reg;

endmodule

// File: tb/tb_async_reset_sync_load_register.sv
// Directed bench for async_reset_sync_load_register: a 4-bit default instance
// and an 8-bit instance with a non-zero reset value, sharing clock and reset.
module tb_async_reset_sync_load_register;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic       valid;
  logic       changed;
  logic [3:0] q_prev;

  logic       load8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic       valid8;
  logic       changed8;
  logic [7:0] q_prev8;

  int checks = 0;
  int errors = 0;

  async_reset_sync_load_register #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .d(d),
    .q(q), .valid(valid), .changed(changed), .q_prev(q_prev)
  );

  async_reset_sync_load_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .reset(reset), .load(load8), .d(d8),
    .q(q8), .valid(valid8), .changed(changed8), .q_prev(q_prev8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] eq, input logic [3:0] eqp,
                        input logic ev, input logic ec);
    check({tag, ".q"}, {4'h0, q}, {4'h0, eq});
    check({tag, ".q_prev"}, {4'h0, q_prev}, {4'h0, eqp});
    check({tag, ".valid"}, {7'h0, valid}, {7'h0, ev});
    check({tag, ".changed"}, {7'h0, changed}, {7'h0, ec});
    $display("%s: load=%b d=%b q=%b q_prev=%b valid=%b changed=%b",
             tag, load, d, q, q_prev, valid, changed);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; d = 4'b0000;
    load8 = 1'b0; d8 = 8'h3C;

    // 1: power-up reset held over several edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check4("t1_reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("t1_q8", q8, 8'hA5);
      check("t1_qprev8", q_prev8, 8'hA5);
    end

    // 2: load after release
    @(negedge clk); reset = 1'b1; load = 1'b1; d = 4'b1010;
    tick();
    check4("t2_first", 4'b1010, 4'b0000, 1'b1, 1'b1);
    check("t2_q8_hold", q8, 8'hA5);
    check("t2_valid8", {7'h0, valid8}, 8'h00);
    tick();
    check4("t2_repeat", 4'b1010, 4'b1010, 1'b1, 1'b0);

    // 3: update while load held
    @(negedge clk); d = 4'b1100;
    tick();
    check4("t3_update", 4'b1100, 4'b1010, 1'b1, 1'b1);
    tick();
    check4("t3_settle", 4'b1100, 4'b1100, 1'b1, 1'b0);

    // 4: hold with d moving
    @(negedge clk); load = 1'b0; d = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      check4("t4_hold", 4'b1100, 4'b1100, 1'b1, 1'b0);
    end

    // 8-bit instance: load equal to reset value, then a different value
    @(negedge clk); load8 = 1'b1; d8 = 8'hA5;
    tick();
    check("t4_q8_same", q8, 8'hA5);
    check("t4_valid8", {7'h0, valid8}, 8'h01);
    check("t4_changed8_same", {7'h0, changed8}, 8'h00);
    @(negedge clk); d8 = 8'h3C;
    tick();
    check("t4_q8_new", q8, 8'h3C);
    check("t4_qprev8", q_prev8, 8'hA5);
    check("t4_changed8", {7'h0, changed8}, 8'h01);
    @(negedge clk); load8 = 1'b0;

    // 5: asynchronous reset between edges
    @(posedge clk); #3; reset = 1'b0;
    #1;
    check4("t5_async", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("t5_q8", q8, 8'hA5);
    load = 1'b1; d = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      check4("t5_held", 4'b0000, 4'b0000, 1'b0, 1'b0);
    end

    // 6: reset coincident with a load edge
    @(negedge clk); reset = 1'b1; load = 1'b1; d = 4'b0110;
    tick();
    check4("t6_preload", 4'b0110, 4'b0000, 1'b1, 1'b1);
    @(posedge clk); reset = 1'b0; load = 1'b1; d = 4'b0101;
    #1;
    check4("t6_coincide", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1; load = 1'b0;
    tick();
    check4("t6_release", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("t6_q8_release", q8, 8'hA5);
    check("t6_valid8", {7'h0, valid8}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
